// File: rtl/random_pkg.sv
// Shared constants for the snake game's random position generator:
// LFSR geometry, tap positions, default seeds and default playfield size.
package random_pkg;

  localparam int LFSR_W  = 16;
  localparam int COORD_W = 7;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in Fibonacci form
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED_X = 16'hACE1;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED_Y = 16'h1D2B;

  localparam int DEFAULT_GRID_W = 64;
  localparam int DEFAULT_GRID_H = 48;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
    return {l[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr16_mod.sv
// One free-running 16-bit LFSR with zero-lock recovery, reduced into 0..M-1
// by cascaded conditional subtraction and presented as a registered index.
module lfsr16_mod
  import random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED_X,
  parameter int                M    = DEFAULT_GRID_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] rand_val
);

  localparam int STAGES = (128 + M - 1) / M - 1;

  if (M < 1 || M > 128) begin : g_bad_m
    $fatal(1, "lfsr16_mod: M must be in 1..128");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr16_mod: SEED must be nonzero");
  end

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [COORD_W-1:0] mapped;

  // An all-zero register would lock up forever, so reload the seed instead
  always_comb begin
    lfsr_next = lfsr_step(lfsr);
    if (lfsr == '0) begin
      lfsr_next = SEED;
    end
  end

  always_comb begin
    mapped = lfsr[COORD_W-1:0];
    for (int i = 0; i < STAGES; i++) begin
      if (int'(mapped) >= M) begin
        mapped = mapped - COORD_W'(M);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= SEED;
      rand_val <= '0;
    end else begin
      lfsr     <= lfsr_next;
      rand_val <= mapped;
    end
  end

endmodule

// File: rtl/random_pos_gen.sv
// Free-running pseudo-random X/Y cell generator for food placement; two
// independent LFSR streams, sampled by the game logic whenever it likes.
module random_pos_gen
  import random_pkg::*;
#(
  parameter int                GRID_W = DEFAULT_GRID_W,
  parameter int                GRID_H = DEFAULT_GRID_H,
  parameter logic [LFSR_W-1:0] SEED_X = DEFAULT_SEED_X,
  parameter logic [LFSR_W-1:0] SEED_Y = DEFAULT_SEED_Y
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] randX,
  output logic [COORD_W-1:0] randY
);

  // Identical seeds would make X and Y march in lockstep
  if (SEED_X == SEED_Y) begin : g_same_seed
    $fatal(1, "random_pos_gen: SEED_X and SEED_Y must differ");
  end

  lfsr16_mod #(
    .SEED(SEED_X),
    .M   (GRID_W)
  ) u_x (
    .clk     (clk),
    .rst     (rst),
    .rand_val(randX)
  );

  lfsr16_mod #(
    .SEED(SEED_Y),
    .M   (GRID_H)
  ) u_y (
    .clk     (clk),
    .rst     (rst),
    .rand_val(randY)
  );

endmodule

// File: tb/tb_random_pos_gen.sv
// Self-checking bench for random_pos_gen against an arithmetic model of the
// two LFSR streams and their modulo reduction.
module tb_random_pos_gen;

  localparam int GW = 64;
  localparam int GH = 48;
  localparam int SX = 'hACE1;
  localparam int SY = 'h1D2B;

  logic       clk;
  logic       rst;
  logic [6:0] randX;
  logic [6:0] randY;

  int checkCount  = 0;
  int errorCount  = 0;
  int mx;
  int my;
  bit trackOn     = 0;
  int cycleCount  = 0;
  int firstReturn = -1;
  int zeroSeen    = 0;
  bit seenX [GW];
  bit seenY [GH];

  random_pos_gen dut (
    .clk  (clk),
    .rst  (rst),
    .randX(randX),
    .randY(randY)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int modelStep(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 'hFFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs n cycles, comparing each registered output to the model value
  task automatic applyStimulus(input int n);
    int expX;
    int expY;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      expX = (mx & 127) % GW;
      expY = (my & 127) % GH;
      mx = modelStep(mx);
      my = modelStep(my);
      checkOutput("randX", 32'(randX), 32'(expX));
      checkOutput("randY", 32'(randY), 32'(expY));
      if (trackOn) begin
        cycleCount++;
        checkOutput("rangeX", 32'(randX < GW), 32'd1);
        checkOutput("rangeY", 32'(randY < GH), 32'd1);
        if (randX < GW) seenX[randX] = 1'b1;
        if (randY < GH) seenY[randY] = 1'b1;
        if (dut.u_x.lfsr == 16'hACE1 && firstReturn < 0) firstReturn = cycleCount;
        if (dut.u_x.lfsr == 16'h0000) zeroSeen++;
      end
    end
  endtask

  // Asynchronous reset between edges, released on the following negedge
  task automatic doReset(input int offset);
    #(offset);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_x", 32'(randX), 32'd0);
    checkOutput("async_rst_y", 32'(randY), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mx = SX;
    my = SY;
  endtask

  task automatic checkRelease();
    @(negedge clk);
    checkOutput("rel1_x", 32'(randX), 32'd33);
    checkOutput("rel1_y", 32'(randY), 32'd43);
    @(negedge clk);
    checkOutput("rel2_x", 32'(randX), 32'd3);
    checkOutput("rel2_y", 32'(randY), 32'd38);
    mx = modelStep(modelStep(SX));
    my = modelStep(modelStep(SY));
  endtask

  initial begin
    rst = 1'b0;
    mx  = SX;
    my  = SY;

    #5;
    checkOutput("por_x_5", 32'(randX), 32'd0);
    checkOutput("por_y_5", 32'(randY), 32'd0);
    #45;
    checkOutput("por_x_50", 32'(randX), 32'd0);
    checkOutput("por_y_50", 32'(randY), 32'd0);
    #45;
    checkOutput("por_x_95", 32'(randX), 32'd0);
    checkOutput("por_y_95", 32'(randY), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    checkRelease();
    applyStimulus(498);
    doReset(3);
    checkRelease();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(int'($urandom_range(20, 300)));
      doReset(int'($urandom_range(1, 8)));
      checkRelease();
    end

    doReset(int'($urandom_range(1, 8)));
    trackOn    = 1'b1;
    cycleCount = 0;
    applyStimulus(70000);
    trackOn    = 1'b0;
    checkOutput("period_x", 32'(firstReturn), 32'd65535);
    checkOutput("never_zero_x", 32'(zeroSeen), 32'd0);
    for (int v = 0; v < GW; v++) checkOutput($sformatf("coverX_%0d", v), 32'(seenX[v]), 32'd1);
    for (int v = 0; v < GH; v++) checkOutput($sformatf("coverY_%0d", v), 32'(seenY[v]), 32'd1);

    @(negedge clk);
    #2;
    force dut.u_x.lfsr = 16'h0000;
    #1;
    checkOutput("zlock_next", 32'(dut.u_x.lfsr_next), 32'hACE1);
    checkOutput("zlock_map", 32'(dut.u_x.mapped), 32'd0);
    release dut.u_x.lfsr;
    doReset(1);
    checkRelease();
    applyStimulus(int'($urandom_range(10, 50)));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
